id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the 16-bit simplified MIPS datapath. Decodes the 16-bit instruction word from the decode stage into control bits and the 4-bit ALU operation code, and registers operands, immediate and destination. In the execute cycle it selects forwarded operands and the immediate, and drives the ALU's `op`, `a` and `b` inputs directly. It also detects load-use hazards and inserts bubbles.

---
 rtl/id_ex_stage.sv | 211 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the 16-bit MIPS datapath.
// Decodes the incoming instruction into control bits, registers operands, and
// in the execute cycle forwards results and drives the ALU inputs. It also
// detects load-use hazards and inserts a one-cycle bubble.
module id_ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic [15:0] id_rs_data,
    input  logic [15:0] id_rt_data,
    input  logic        hold,
    input  logic        flush,
    input  logic        exmem_regwrite,
    input  logic [1:0]  exmem_rd,
    input  logic [15:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [1:0]  memwb_rd,
    input  logic [15:0] memwb_data,
    output logic        load_use_stall,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] ex_store_data,
    output logic [15:0] ex_imm,
    output logic [1:0]  ex_rd,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_branch,
    output logic        ex_branch_ne,
    output logic        ex_valid
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_NOR  = 4'h4,
        OP_SLT  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LW   = 4'h7,
        OP_SW   = 4'h8,
        OP_BEQ  = 4'h9,
        OP_BNE  = 4'hA
    } opcode_e;

    // Control word carried from decode into execute; all-zero is a bubble.
    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic [1:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       branch_ne;
        logic       imm_src;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Instruction fields from decode.
    logic [3:0] id_opcode;
    logic [1:0] id_rs;
    logic [1:0] id_rt;
    logic [1:0] id_rd;
    logic [7:0] id_imm8;

    assign id_opcode = id_instr[15:12];
    assign id_rs     = id_instr[11:10];
    assign id_rt     = id_instr[9:8];
    assign id_rd     = id_instr[7:6];
    assign id_imm8   = id_instr[7:0];

    // Decoded control and whether the instruction consumes its rt field.
    ctrl_t dec_ctrl;
    logic  dec_reads_rt;
    logic  dec_dst_is_rd;

    // Execute-stage state.
    ctrl_t       ex_ctrl;
    logic [1:0]  ex_rs;
    logic [1:0]  ex_rt;
    logic [15:0] ex_rs_data;
    logic [15:0] ex_rt_data;
    logic [15:0] ex_imm_q;

    // Forwarded operand values.
    logic [15:0] fwd_rs;
    logic [15:0] fwd_rt;

    // Opcode decode into the control word; undefined opcodes stay a bubble.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        dec_ctrl      = BUBBLE;
        dec_reads_rt  = 1'b0;
        dec_dst_is_rd = 1'b0;
        case (opcode_e'(id_opcode))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT: begin
                dec_ctrl.valid    = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_dst_is_rd     = 1'b1;
                dec_reads_rt      = 1'b1;
                case (opcode_e'(id_opcode))
                    OP_SUB:  dec_ctrl.alu_op = 4'b0110;
                    OP_AND:  dec_ctrl.alu_op = 4'b0000;
                    OP_OR:   dec_ctrl.alu_op = 4'b0001;
                    OP_NOR:  dec_ctrl.alu_op = 4'b1100;
                    OP_SLT:  dec_ctrl.alu_op = 4'b0111;
                    default: dec_ctrl.alu_op = 4'b0010;
                endcase
            end
            OP_ADDI: begin
                dec_ctrl.valid    = 1'b1;
                dec_ctrl.alu_op   = 4'b0010;
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.imm_src  = 1'b1;
            end
            OP_LW: begin
                dec_ctrl.valid    = 1'b1;
                dec_ctrl.alu_op   = 4'b0010;
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.memread  = 1'b1;
                dec_ctrl.imm_src  = 1'b1;
            end
            OP_SW: begin
                dec_ctrl.valid    = 1'b1;
                dec_ctrl.alu_op   = 4'b0010;
                dec_ctrl.memwrite = 1'b1;
                dec_ctrl.imm_src  = 1'b1;
                dec_reads_rt      = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_ctrl.valid     = 1'b1;
                dec_ctrl.alu_op    = 4'b0110;
                dec_ctrl.branch    = 1'b1;
                dec_ctrl.branch_ne = (id_opcode == OP_BNE);
                dec_reads_rt       = 1'b1;
            end
            default: ;
        endcase
        // Only register-writing instructions carry a destination.
        if (dec_ctrl.regwrite)
            dec_ctrl.rd = dec_dst_is_rd ? id_rd : id_rt;
    end

    // Load-use hazard: a load in execute whose destination decode wants to read.
    assign load_use_stall = ex_ctrl.valid && ex_ctrl.memread && id_valid &&
                            (ex_ctrl.rd != 2'd0) &&
                            ((ex_ctrl.rd == id_rs) ||
                             ((ex_ctrl.rd == id_rt) && dec_reads_rt));

    // Pipeline register: reset, then flush, then hold, then stall, then capture.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from pre-edge values.
        if (reset) begin
            ex_ctrl    <= BUBBLE;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm_q   <= '0;
        end else if (!hold || flush) begin
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm_q   <= {{8{id_imm8[7]}}, id_imm8};
            if (flush || load_use_stall || !id_valid)
                ex_ctrl <= BUBBLE;
            else
                ex_ctrl <= dec_ctrl;
        end
    end

    // Operand forwarding: EX/MEM beats MEM/WB beats the register file; r0 is zero.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (ex_rs == 2'd0)
            fwd_rs = 16'h0000;
        else if (exmem_regwrite && (exmem_rd == ex_rs))
            fwd_rs = exmem_result;
        else if (memwb_regwrite && (memwb_rd == ex_rs))
            fwd_rs = memwb_data;

        fwd_rt = ex_rt_data;
        if (ex_rt == 2'd0)
            fwd_rt = 16'h0000;
        else if (exmem_regwrite && (exmem_rd == ex_rt))
            fwd_rt = exmem_result;
        else if (memwb_regwrite && (memwb_rd == ex_rt))
            fwd_rt = memwb_data;
    end

    assign alu_op        = ex_ctrl.alu_op;
    assign alu_a         = fwd_rs;
    assign alu_b         = ex_ctrl.imm_src ? ex_imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_imm        = ex_imm_q;
    assign ex_rd         = ex_ctrl.rd;
    assign ex_regwrite   = ex_ctrl.regwrite;
    assign ex_memread    = ex_ctrl.memread;
    assign ex_memwrite   = ex_ctrl.memwrite;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_branch_ne  = ex_ctrl.branch_ne;
    assign ex_valid      = ex_ctrl.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] id_instr;
    logic        id_valid;
    logic [15:0] id_rs_data;
    logic [15:0] id_rt_data;
    logic        hold;
    logic        flush;
    logic        exmem_regwrite;
    logic [1:0]  exmem_rd;
    logic [15:0] exmem_result;
    logic        memwb_regwrite;
    logic [1:0]  memwb_rd;
    logic [15:0] memwb_data;
    logic        load_use_stall;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] ex_store_data;
    logic [15:0] ex_imm;
    logic [1:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_branch;
    logic        ex_branch_ne;
    logic        ex_valid;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage dut (
        .clock          (clock),
        .reset          (reset),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .hold           (hold),
        .flush          (flush),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .load_use_stall (load_use_stall),
        .alu_op         (alu_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .ex_store_data  (ex_store_data),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_branch      (ex_branch),
        .ex_branch_ne   (ex_branch_ne),
        .ex_valid       (ex_valid)
    );

    always #5 clock = ~clock;

    // Build an instruction word: {opcode, rs, rt, imm8}; R-type rd lives in imm8[7:6].
    function automatic logic [15:0] rtype(input logic [3:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs, input logic [1:0] rt);
        return {op, rs, rt, rd, 6'b0};
    endfunction

    function automatic logic [15:0] itype(input logic [3:0] op, input logic [1:0] rs,
                                          input logic [1:0] rt, input logic [7:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        id_instr       = rtype(4'h0, 2'd1, 2'd2, 2'd3);   // add r1,r2,r3
        id_valid       = 1'b1;
        id_rs_data     = 16'h1111;
        id_rt_data     = 16'h2222;
        hold           = 1'b0;
        flush          = 1'b0;
        exmem_regwrite = 1'b0;
        exmem_rd       = 2'd0;
        exmem_result   = 16'h0;
        memwb_regwrite = 1'b0;
        memwb_rd       = 2'd0;
        memwb_data     = 16'h0;

        // Reset held two cycles with a valid add presented.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", ex_valid, 0);
            check("rst_alu_op", alu_op, 4'b0000);
            check("rst_regwrite", ex_regwrite, 0);
            check("rst_alu_a", alu_a, 16'h0);
            check("rst_imm", ex_imm, 16'h0);
            check("rst_stall", load_use_stall, 0);
        end
        reset = 1'b0;

        // sub r3,r1,r2
        id_instr   = rtype(4'h1, 2'd3, 2'd1, 2'd2);
        id_rs_data = 16'h0009;
        id_rt_data = 16'h0004;
        tick();
        check("sub_alu_op", alu_op, 4'b0110);
        check("sub_alu_a", alu_a, 16'h0009);
        check("sub_alu_b", alu_b, 16'h0004);
        check("sub_rd", ex_rd, 2'd3);
        check("sub_regwrite", ex_regwrite, 1);
        check("sub_valid", ex_valid, 1);

        // Hold the sub while exercising forwarding combinationally.
        hold = 1'b1;
        exmem_regwrite = 1'b1; exmem_rd = 2'd1; exmem_result = 16'h0020;
        memwb_regwrite = 1'b1; memwb_rd = 2'd1; memwb_data   = 16'h0030;
        #1;
        check("fwd_exmem_prio", alu_a, 16'h0020);
        exmem_regwrite = 1'b0;
        #1;
        check("fwd_memwb", alu_a, 16'h0030);
        memwb_rd = 2'd2;
        #1;
        check("fwd_memwb_rt", alu_b, 16'h0030);
        check("fwd_memwb_rs_off", alu_a, 16'h0009);
        exmem_regwrite = 1'b1; exmem_rd = 2'd0; memwb_rd = 2'd0;
        #1;
        check("fwd_r0_ignored_a", alu_a, 16'h0009);
        check("fwd_r0_ignored_b", alu_b, 16'h0004);
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        hold = 1'b0;

        // addi r2,r1,-2
        id_instr   = itype(4'h6, 2'd1, 2'd2, 8'hFE);
        id_rs_data = 16'h0005;
        tick();
        check("addi_imm", ex_imm, 16'hFFFE);
        check("addi_alu_b", alu_b, 16'hFFFE);
        check("addi_rd", ex_rd, 2'd2);
        check("addi_alu_a", alu_a, 16'h0005);
        check("addi_regwrite", ex_regwrite, 1);

        // sw r3,4(r1)
        id_instr   = itype(4'h8, 2'd1, 2'd3, 8'h04);
        id_rt_data = 16'h1234;
        tick();
        check("sw_memwrite", ex_memwrite, 1);
        check("sw_regwrite", ex_regwrite, 0);
        check("sw_store", ex_store_data, 16'h1234);
        check("sw_alu_b", alu_b, 16'h0004);
        check("sw_memread", ex_memread, 0);

        // lw r2,0(r1) followed by add r3,r2,r1.
        id_instr = itype(4'h7, 2'd1, 2'd2, 8'h00);
        tick();
        check("lw_memread", ex_memread, 1);
        check("lw_rd", ex_rd, 2'd2);
        id_instr = rtype(4'h0, 2'd3, 2'd2, 2'd1);
        #1;
        check("lu_stall_on", load_use_stall, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_stall_off", load_use_stall, 0);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_op", alu_op, 4'b0010);
        check("lu_add_rd", ex_rd, 2'd3);
        check("lu_add_stall", load_use_stall, 0);

        // lw r2 then rt-match: addi does not read rt, beq does.
        id_instr = itype(4'h7, 2'd1, 2'd2, 8'h00);
        tick();
        id_instr = itype(4'h6, 2'd1, 2'd2, 8'h01);
        #1;
        check("lu_addi_rt_nostall", load_use_stall, 0);
        id_instr = itype(4'h9, 2'd1, 2'd2, 8'h01);
        #1;
        check("lu_beq_rt_stall", load_use_stall, 1);
        id_valid = 1'b0;
        #1;
        check("lu_invalid_nostall", load_use_stall, 0);
        id_valid = 1'b1;

        // Reset while a stall is pending wins.
        reset = 1'b1;
        tick();
        check("rst_stall_valid", ex_valid, 0);
        check("rst_stall_memread", ex_memread, 0);
        check("rst_stall_stall", load_use_stall, 0);
        reset = 1'b0;

        // lw r0 then use of r0: no stall.
        id_instr = itype(4'h7, 2'd1, 2'd0, 8'h00);
        tick();
        check("lw0_memread", ex_memread, 1);
        id_instr = rtype(4'h0, 2'd3, 2'd0, 2'd0);
        #1;
        check("lw0_nostall", load_use_stall, 0);

        // flush and hold together with a valid add.
        id_instr = rtype(4'h0, 2'd1, 2'd2, 2'd3);
        flush = 1'b1; hold = 1'b1;
        tick();
        check("flush_valid", ex_valid, 0);
        check("flush_regwrite", ex_regwrite, 0);
        flush = 1'b0; hold = 1'b0;

        // or r2,r1,r3 then hold for two cycles with different decode input.
        id_instr   = rtype(4'h3, 2'd2, 2'd1, 2'd3);
        id_rs_data = 16'h00F0;
        id_rt_data = 16'h0F00;
        tick();
        check("or_alu_op", alu_op, 4'b0001);
        check("or_alu_b", alu_b, 16'h0F00);
        hold       = 1'b1;
        id_instr   = rtype(4'h1, 2'd1, 2'd3, 2'd3);
        id_rs_data = 16'hAAAA;
        id_rt_data = 16'h5555;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold_alu_op", alu_op, 4'b0001);
            check("hold_alu_a", alu_a, 16'h00F0);
            check("hold_alu_b", alu_b, 16'h0F00);
            check("hold_rd", ex_rd, 2'd2);
            check("hold_valid", ex_valid, 1);
        end
        hold = 1'b0;

        // bne r1,r2
        id_instr = itype(4'hA, 2'd1, 2'd2, 8'h03);
        tick();
        check("bne_alu_op", alu_op, 4'b0110);
        check("bne_branch", ex_branch, 1);
        check("bne_branch_ne", ex_branch_ne, 1);
        check("bne_regwrite", ex_regwrite, 0);

        // beq r1,r2
        id_instr = itype(4'h9, 2'd1, 2'd2, 8'h03);
        tick();
        check("beq_branch", ex_branch, 1);
        check("beq_branch_ne", ex_branch_ne, 0);

        // Illegal opcode 1111 decodes as a bubble.
        id_instr = 16'hF6C0;
        tick();
        check("ill_valid", ex_valid, 0);
        check("ill_alu_op", alu_op, 4'b0000);
        check("ill_regwrite", ex_regwrite, 0);
        check("ill_branch", ex_branch, 0);

        // nor r1,r2,r3 with id_valid low is a bubble; then valid gives nor.
        id_instr = rtype(4'h4, 2'd1, 2'd2, 2'd3);
        id_valid = 1'b0;
        tick();
        check("novalid_valid", ex_valid, 0);
        id_valid = 1'b1;
        tick();
        check("nor_alu_op", alu_op, 4'b1100);
        check("nor_rd", ex_rd, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
